alu_div_signed_wrap: RTL

Signed-division wrapper around the unsigned iterative divider `alu_pipelined_div`. It sits directly in front of and behind the divider:
- Front end: accepts the ALU operator/left/right streams and converts DIVZ (signed) operands to magnitudes.
- Back end: takes the divider's unsigned quotient and remainder and restores the signs.
- A small tag FIFO carries per-operation sign information across the divider, so in-order operation is kept with several operations in flight.

---
 rtl/alu_div_signed_wrap_pkg.sv | 12 +
 rtl/alu_div_signed_wrap_if.sv | 13 +
 rtl/alu_div_tag_fifo.sv | 59 +++++
 rtl/alu_div_signed_wrap.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/alu_div_signed_wrap_pkg.sv
// Shared opcodes and the per-operation sign tag carried across the unsigned divider.
package alu_pkg;

    localparam logic [5:0] ALU_OP_DIVN = 6'd17;
    localparam logic [5:0] ALU_OP_DIVZ = 6'd18;

    typedef struct packed {
        logic neg_q;
        logic neg_r;
    } alu_div_tag_t;

endpackage

// File: rtl/alu_div_signed_wrap_if.sv
// Valid/ack stream channel; data holds stable while valid is high until the ack edge.
interface data_interface #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic             ack;
    logic [WIDTH-1:0] data;

    modport producer (output valid, output data, input ack);
    modport consumer (input valid, input data, output ack);
    modport master   (output valid, output data, input ack);
    modport slave    (input valid, input data, output ack);
endinterface

// File: rtl/alu_div_tag_fifo.sv
// Small FIFO of sign tags; a push and pop in the same cycle keeps occupancy, even when full or empty.
module alu_div_tag_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  alu_div_tag_t push_data_i,
    input  logic         pop_i,
    output alu_div_tag_t pop_data_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    alu_div_tag_t    mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & (~empty_o | push_i);
    // An empty FIFO popped alongside a push hands the incoming tag straight through.
    assign pop_data_o = empty_o ? push_data_i : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (do_push) mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/alu_div_signed_wrap.sv
// Signed-division wrapper: strips operand signs before the unsigned divider and restores them after.
// Optional ALU_DIV_ZERO_BYPASS_EN answers zero-divisor operations locally without using the divider.
module alu_div_signed_wrap
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int OPCODE_WIDTH = 6,
    parameter int TAG_DEPTH    = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    data_interface.consumer  operator,
    data_interface.consumer  left,
    data_interface.consumer  right,
    data_interface.producer  result,
    data_interface.producer  overflow,
    data_interface.producer  div_operator,
    data_interface.producer  div_left,
    data_interface.producer  div_right,
    data_interface.consumer  div_result,
    data_interface.consumer  div_overflow
);
    typedef logic [DATA_WIDTH-1:0]   word_t;
    typedef logic [OPCODE_WIDTH-1:0] opc_t;

    function automatic word_t neg_w(input word_t v);
        return word_t'('0 - v);
    endfunction

    opc_t         op_in;
    word_t        l_in, r_in;
    logic         in_vld, is_divz, is_zero;
    logic         acc_div, acc_byp, div_xfer, be_take;
    alu_div_tag_t push_tag, pop_tag;
    logic         tag_full, tag_empty;

    logic  div_vld_q, div_vld_d;
    opc_t  div_op_q, div_op_d;
    word_t div_l_q, div_l_d, div_r_q, div_r_d;
    logic  res_vld_q, res_vld_d, ovf_vld_q, ovf_vld_d;
    word_t res_data_q, res_data_d, ovf_data_q, ovf_data_d;

    assign op_in   = operator.data;
    assign l_in    = left.data;
    assign r_in    = right.data;
    assign in_vld  = operator.valid & left.valid & right.valid;
    assign is_divz = (op_in == OPCODE_WIDTH'(ALU_OP_DIVZ));

    assign push_tag.neg_q = is_divz & (l_in[DATA_WIDTH-1] ^ r_in[DATA_WIDTH-1]);
    assign push_tag.neg_r = is_divz & l_in[DATA_WIDTH-1];

    assign div_xfer = div_vld_q & div_operator.ack & div_left.ack & div_right.ack;

`ifdef ALU_DIV_ZERO_BYPASS_EN
    // Zero divisors only bypass once nothing is in flight, so results stay in issue order.
    assign is_zero = (r_in == '0);
    assign acc_byp = reset_n & in_vld & is_zero & tag_empty & ~res_vld_q & ~ovf_vld_q;
`else
    assign is_zero = 1'b0;
    assign acc_byp = 1'b0;
`endif

    assign acc_div = reset_n & in_vld & ~is_zero & (~div_vld_q | div_xfer) & ~tag_full;

    assign operator.ack = acc_div | acc_byp;
    assign left.ack     = acc_div | acc_byp;
    assign right.ack    = acc_div | acc_byp;

    assign div_operator.valid = div_vld_q;
    assign div_operator.data  = div_op_q;
    assign div_left.valid     = div_vld_q;
    assign div_left.data      = div_l_q;
    assign div_right.valid    = div_vld_q;
    assign div_right.data     = div_r_q;

    assign be_take = div_result.valid & div_overflow.valid & ~tag_empty
                   & (~res_vld_q | result.ack) & (~ovf_vld_q | overflow.ack);

    assign div_result.ack   = be_take;
    assign div_overflow.ack = be_take;

    assign result.valid   = res_vld_q;
    assign result.data    = res_data_q;
    assign overflow.valid = ovf_vld_q;
    assign overflow.data  = ovf_data_q;

    alu_div_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk_i       (clock),
        .rst_ni      (reset_n),
        .push_i      (acc_div),
        .push_data_i (push_tag),
        .pop_i       (be_take),
        .pop_data_o  (pop_tag),
        .full_o      (tag_full),
        .empty_o     (tag_empty)
    );

    always_comb begin
        div_vld_d = div_vld_q;
        div_op_d  = div_op_q;
        div_l_d   = div_l_q;
        div_r_d   = div_r_q;
        if (div_xfer) div_vld_d = 1'b0;
        if (acc_div) begin
            div_vld_d = 1'b1;
            div_op_d  = op_in;
            div_l_d   = (is_divz && l_in[DATA_WIDTH-1]) ? neg_w(l_in) : l_in;
            div_r_d   = (is_divz && r_in[DATA_WIDTH-1]) ? neg_w(r_in) : r_in;
        end
    end

    // Output valids are loaded together but drained independently.
    always_comb begin
        res_vld_d  = res_vld_q & ~result.ack;
        ovf_vld_d  = ovf_vld_q & ~overflow.ack;
        res_data_d = res_data_q;
        ovf_data_d = ovf_data_q;
        if (be_take) begin
            res_vld_d  = 1'b1;
            ovf_vld_d  = 1'b1;
            res_data_d = pop_tag.neg_q ? neg_w(div_result.data)   : div_result.data;
            ovf_data_d = pop_tag.neg_r ? neg_w(div_overflow.data) : div_overflow.data;
        end
        if (acc_byp) begin
            res_vld_d  = 1'b1;
            ovf_vld_d  = 1'b1;
            res_data_d = '1;
            ovf_data_d = l_in;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_vld_q  <= 1'b0;
            div_op_q   <= '0;
            div_l_q    <= '0;
            div_r_q    <= '0;
            res_vld_q  <= 1'b0;
            ovf_vld_q  <= 1'b0;
            res_data_q <= '0;
            ovf_data_q <= '0;
        end else begin
            div_vld_q  <= div_vld_d;
            div_op_q   <= div_op_d;
            div_l_q    <= div_l_d;
            div_r_q    <= div_r_d;
            res_vld_q  <= res_vld_d;
            ovf_vld_q  <= ovf_vld_d;
            res_data_q <= res_data_d;
            ovf_data_q <= ovf_data_d;
        end
    end

endmodule
